// File: rtl/spi_peripheral_pkg.sv
// ----------------------------------------------------------------------------
// spi_peripheral_pkg
// Shared definitions for the SPI register-load block: register addresses,
// frame geometry, bit-counter marks and the transaction FSM state type.
// ----------------------------------------------------------------------------
package spi_peripheral_pkg;

   // Register map
   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;

   // Frame: R/W bit, 7-bit address, 8-bit data, MSB first
   localparam int FRAME_BITS = 16;

   // Bit-counter marks: a complete frame, and the saturating "too long" value
   localparam logic [4:0] CNT_FRAME    = 5'd16;
   localparam logic [4:0] CNT_OVERLONG = 5'd17;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

endpackage

// File: rtl/spi_peripheral_sync_edge_detect.sv
// ----------------------------------------------------------------------------
// spi_peripheral_sync_edge_detect
// Brings one asynchronous pin into the clk domain through a STAGES-deep
// flop chain, then compares the last stage with one extra delay flop to
// produce single-cycle rise/fall strobes.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset (chain loads RST_VAL)
//   d_i      asynchronous input pin
//   level_o  synchronised level
//   rise_o   one-cycle strobe on synchronised 0->1
//   fall_o   one-cycle strobe on synchronised 1->0
// ----------------------------------------------------------------------------
module spi_peripheral_sync_edge_detect #(
   parameter int   STAGES  = 2,     // metastability depth, 2 or more
   parameter logic RST_VAL = 1'b0   // idle level of the pin
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         dly_q  <= RST_VAL;
      end else begin
         // NOTE: non-blocking assignments let every stage sample its
         // predecessor's old value, so the chain really is STAGES flops deep.
         sync_q <= {sync_q[STAGES-2:0], d_i};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  =  sync_q[STAGES-1] & ~dly_q;
   assign fall_o  = ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/spi_peripheral.sv
// ----------------------------------------------------------------------------
// spi_peripheral
// SPI mode-0, write-only target that loads the five PWM control registers.
// sclk/copi/ncs are oversampled in the clk domain; nothing runs on sclk.
// Frame (16 bits, MSB first): [15] write=1, [14:8] address, [7:0] data.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   sclk, copi, ncs     SPI pins, asynchronous to clk
//   en_reg_out_7_0      reg 0x00    en_reg_out_15_8   reg 0x01
//   en_reg_pwm_7_0      reg 0x02    en_reg_pwm_15_8   reg 0x03
//   pwm_duty_cycle      reg 0x04
//   txn_done            one-cycle pulse when a valid write commits
//   txn_error           one-cycle pulse when a frame is rejected
// ----------------------------------------------------------------------------
module spi_peripheral
   import spi_peripheral_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       txn_done,
   output logic       txn_error
);

   // ---------------------------------------------------------------- inputs
   logic sclk_rise, sclk_level_unused, sclk_fall_unused;
   logic ncs_level, ncs_rise, ncs_fall;
   logic copi_level, copi_rise_unused, copi_fall_unused;

   spi_peripheral_sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d_i(sclk),
      .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
   );

   spi_peripheral_sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
      .clk(clk), .rst(rst), .d_i(ncs),
      .level_o(ncs_level), .rise_o(ncs_rise), .fall_o(ncs_fall)
   );

   // Same depth as sclk, so copi is aligned with the sclk rising strobe.
   spi_peripheral_sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
      .clk(clk), .rst(rst), .d_i(copi),
      .level_o(copi_level), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
   );

   // ----------------------------------------------------------------- state
   state_e                  state_q;
   logic [FRAME_BITS-1:0]   shift_q;
   logic [4:0]              cnt_q;
   logic [7:0]              out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
   logic                    done_q, error_q;

   // --------------------------------------------------------- next values
   logic [FRAME_BITS-1:0]   shift_d;
   logic [4:0]              cnt_d;
   logic [6:0]              frame_addr;
   logic [7:0]              frame_data;
   logic                    write_ok;

   always_comb begin
      shift_d    = {shift_q[FRAME_BITS-2:0], copi_level};
      // Saturate so that any frame longer than 16 bits reads as overlong.
      cnt_d      = (cnt_q == CNT_OVERLONG) ? cnt_q : cnt_q + 5'd1;
      frame_addr = shift_q[14:8];
      frame_data = shift_q[7:0];
      write_ok   = (cnt_q == CNT_FRAME) && shift_q[15] && (frame_addr <= MAX_ADDR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         // NOTE: the control registers drive the PWM block directly, so they
         // must come out of reset at a known (all-off) value.
         out_lo_q <= '0;
         out_hi_q <= '0;
         pwm_lo_q <= '0;
         pwm_hi_q <= '0;
         duty_q   <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (ncs_fall) begin
                  shift_q <= '0;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end

            SHIFT: begin
               // ncs rising takes priority over a coincident sclk edge.
               if (ncs_rise) begin
                  state_q <= COMMIT;
               end else if (sclk_rise && !ncs_level) begin
                  shift_q <= shift_d;
                  cnt_q   <= cnt_d;
               end
            end

            COMMIT: begin
               if (write_ok) begin
                  done_q <= 1'b1;
                  case (frame_addr)
                     ADDR_EN_OUT_LO: out_lo_q <= frame_data;
                     ADDR_EN_OUT_HI: out_hi_q <= frame_data;
                     ADDR_EN_PWM_LO: pwm_lo_q <= frame_data;
                     ADDR_EN_PWM_HI: pwm_hi_q <= frame_data;
                     ADDR_DUTY:      duty_q   <= frame_data;
                     default:        ;
                  endcase
               end else begin
                  error_q <= 1'b1;
               end
               state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign en_reg_out_7_0  = out_lo_q;
   assign en_reg_out_15_8 = out_hi_q;
   assign en_reg_pwm_7_0  = pwm_lo_q;
   assign en_reg_pwm_15_8 = pwm_hi_q;
   assign pwm_duty_cycle  = duty_q;
   assign txn_done        = done_q;
   assign txn_error       = error_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// ----------------------------------------------------------------------------
// tb_spi_peripheral
// Directed, table-driven bench for spi_peripheral plus hand-written
// sequences for reset mid-frame, commit latency, back-to-back frames and
// the ncs/sclk coincidence case.
// ----------------------------------------------------------------------------
module tb_spi_peripheral;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = SYNC_STAGES + 2;  // sclk half-period in clk cycles

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk, copi, ncs;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       txn_done, txn_error;

   always #5 clk = ~clk;

   spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle),
      .txn_done(txn_done), .txn_error(txn_error)
   );

   logic [39:0] regs_now;
   assign regs_now = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                      en_reg_pwm_15_8, pwm_duty_cycle};

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int done_cnt = 0;
   int err_cnt  = 0;

   // Pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (txn_done === 1'b1)  done_cnt++;
      if (txn_error === 1'b1) err_cnt++;
   end

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Mode-0 frame: copi set while sclk low, sampled on sclk rise.
   // With coincident=1 an extra sclk rise is issued together with ncs rise.
   task automatic send_frame(input logic [31:0] bits, input int nbits, input bit coincident);
      logic [31:0] b;
      b   = bits;
      ncs = 1'b0;
      wait_clk(HALF);
      for (int i = nbits - 1; i >= 0; i--) begin
         copi = b[i];
         wait_clk(HALF);
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
      if (coincident) begin
         copi = 1'b0;
         wait_clk(HALF);
         sclk = 1'b1;
         ncs  = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end else begin
         wait_clk(HALF);
         ncs = 1'b1;
      end
   endtask

   typedef struct {
      logic [31:0] frame;
      int          nbits;
      int          exp_done;
      int          exp_err;
      logic [39:0] exp_regs;  // {reg0, reg1, reg2, reg3, reg4}
   } vec_t;

   vec_t vecs[10];

   initial begin
      int d0, e0;

      vecs[0] = '{32'h81AA,  16, 1, 0, 40'hF0_AA_00_00_00};
      vecs[1] = '{32'h8255,  16, 1, 0, 40'hF0_AA_55_00_00};
      vecs[2] = '{32'h8301,  16, 1, 0, 40'hF0_AA_55_01_00};
      vecs[3] = '{32'h8480,  16, 1, 0, 40'hF0_AA_55_01_80};
      vecs[4] = '{32'h8512,  16, 0, 1, 40'hF0_AA_55_01_80};  // bad address
      vecs[5] = '{32'h0433,  16, 0, 1, 40'hF0_AA_55_01_80};  // read bit
      vecs[6] = '{32'h4411,  15, 0, 1, 40'hF0_AA_55_01_80};  // short frame
      vecs[7] = '{32'h10411, 17, 0, 1, 40'hF0_AA_55_01_80};  // overlong frame
      vecs[8] = '{32'h0,      0, 0, 1, 40'hF0_AA_55_01_80};  // ncs glitch
      vecs[9] = '{32'h8004,  16, 1, 0, 40'h04_AA_55_01_80};

      // ---------------------------------------------------------- reset
      rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
      wait_clk(3);
      check("reset regs",      regs_now, 40'h0);
      check("reset txn_done",  {39'b0, txn_done}, 40'h0);
      check("reset txn_error", {39'b0, txn_error}, 40'h0);
      rst = 1'b0;
      wait_clk(3);

      // -------------------------------- write, then reset mid-frame
      send_frame(32'h8077, 16, 1'b0);
      wait_clk(10);
      check("pre-reset write", regs_now, 40'h77_00_00_00_00);
      d0 = done_cnt; e0 = err_cnt;
      ncs = 1'b0;
      wait_clk(HALF);
      for (int i = 15; i >= 8; i--) begin
         copi = 1'b1;
         wait_clk(HALF);
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
      rst = 1'b1; ncs = 1'b1; copi = 1'b0;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(10);
      check("mid-frame reset regs",  regs_now, 40'h0);
      check("mid-frame reset done",  40'(done_cnt - d0), 40'd0);
      check("mid-frame reset error", 40'(err_cnt - e0), 40'd0);

      // ------------------------------------- commit latency, 0x80F0
      d0 = done_cnt;
      send_frame(32'h80F0, 16, 1'b0);   // returns on the negedge ncs rises
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      check("latency reg0 early",  {32'b0, en_reg_out_7_0}, 40'h00);
      check("latency done early",  {39'b0, txn_done}, 40'h0);
      @(posedge clk);
      #1;
      check("latency reg0 on time", {32'b0, en_reg_out_7_0}, 40'hF0);
      check("latency done pulse",   {39'b0, txn_done}, 40'h1);
      @(posedge clk);
      #1;
      check("latency done cleared", {39'b0, txn_done}, 40'h0);
      wait_clk(5);
      check("latency other regs", regs_now, 40'hF0_00_00_00_00);
      check("latency done count", 40'(done_cnt - d0), 40'd1);

      // ------------------------------------------------ vector table
      for (int i = 0; i < 10; i++) begin
         d0 = done_cnt; e0 = err_cnt;
         send_frame(vecs[i].frame, vecs[i].nbits, 1'b0);
         wait_clk(10);
         check($sformatf("vec%0d regs", i),  regs_now, vecs[i].exp_regs);
         check($sformatf("vec%0d done", i),  40'(done_cnt - d0), 40'(vecs[i].exp_done));
         check($sformatf("vec%0d error", i), 40'(err_cnt - e0),  40'(vecs[i].exp_err));
      end

      // -------------------- back-to-back, minimum ncs-high gap between
      d0 = done_cnt;
      send_frame(32'h8311, 16, 1'b0);
      wait_clk(SYNC_STAGES + 2);
      check("b2b first commit", {32'b0, en_reg_pwm_15_8}, 40'h11);
      send_frame(32'h8322, 16, 1'b0);
      wait_clk(10);
      check("b2b regs",  regs_now, 40'h04_AA_55_22_80);
      check("b2b done",  40'(done_cnt - d0), 40'd2);

      // --------------------- ncs rise coincident with a 17th sclk rise
      d0 = done_cnt; e0 = err_cnt;
      send_frame(32'h8299, 16, 1'b1);
      wait_clk(10);
      check("coincident regs",  regs_now, 40'h04_AA_99_22_80);
      check("coincident done",  40'(done_cnt - d0), 40'd1);
      check("coincident error", 40'(err_cnt - e0), 40'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI mode-0 write-only target that loads the five control registers driving pwm_peripheral (output enables, PWM enables, duty cycle). Sits directly upstream of pwm_peripheral in the top level. Inputs are sourced from ui_in pins (sclk, copi, ncs). All SPI inputs are oversampled in the system clock domain; no logic is clocked by sclk.

Parameters:
SYNC_STAGES, 2, flip-flop depth of input synchronisers on sclk/copi/ncs (min 2)
MAX_ADDR, 7'h04, highest valid register address; writes above it are dropped

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from controller, async to clk
copi  input  1  SPI data from controller, async to clk
ncs  input  1  SPI chip select, active-low, async to clk
en_reg_out_7_0  output  8  reg 0x00, output enable bits 7:0
en_reg_out_15_8  output  8  reg 0x01, output enable bits 15:8
en_reg_pwm_7_0  output  8  reg 0x02, PWM enable bits 7:0
en_reg_pwm_15_8  output  8  reg 0x03, PWM enable bits 15:8
pwm_duty_cycle  output  8  reg 0x04, duty cycle (0x00 = 0%, 0xFF = 100%)
txn_done  output  1  one-cycle pulse when a valid write commits
txn_error  output  1  one-cycle pulse when a transaction is rejected

Behaviour:
- Reset (async, rst=1): all five registers 0x00, txn_done=0, txn_error=0, shift reg 0, bit counter 0, FSM IDLE, synchronisers reset ncs=1, sclk=0, copi=0. Reset asserted mid-transaction discards it; no partial commit.
- Frame: 16 bits, MSB first, copi sampled on synchronised sclk rising edge while synchronised ncs=0. bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Edge detect: compare last sync stage with one extra delay flop; edges used only when ncs_sync=0.
- FSM: IDLE -> SHIFT on ncs_sync falling edge (shift reg and bit counter cleared). SHIFT: each sclk rising edge shifts in copi, counter increments, saturating at 17 (17 = overlong). SHIFT -> COMMIT on ncs_sync rising edge. COMMIT -> IDLE unconditionally after one cycle.
- Same cycle ncs_sync rises and sclk rising edge detected: ncs wins, sclk edge ignored.
- COMMIT: write accepted iff count==16 AND bit15=1 AND address<=MAX_ADDR; then target register <= data and txn_done=1 for that cycle. Otherwise no register changes and txn_error=1 for that cycle (short frame, overlong frame, read bit, bad address).
- Latency: register value visible on output exactly SYNC_STAGES+2 clk rising edges after ncs pin rises (given setup met).
- Registers hold value indefinitely; only a valid write changes one register; other four unchanged.
- Min SPI timing: sclk high and low each >= SYNC_STAGES+1 clk periods; faster sclk unsupported.
- ncs glitch low->high with zero sclk edges: count=0 -> txn_error pulse, no write.

Decomposition:
- Shared package: register address constants (ADDR_EN_OUT_LO=0x00, ADDR_EN_OUT_HI=0x01, ADDR_EN_PWM_LO=0x02, ADDR_EN_PWM_HI=0x03, ADDR_DUTY=0x04), FRAME_BITS=16, FSM state enum {IDLE, SHIFT, COMMIT}.
- One sub-module natural: sync_edge_detect (SYNC_STAGES-deep synchroniser + delay flop, outputs level, rise, fall); instantiated three times (sclk, ncs; copi uses level only).

Test Plan:
- Reset: assert rst mid-frame after 8 bits -> all registers 0x00, no txn_done/txn_error; subsequent frame works normally.
- Valid write: frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0=0xF0 exactly SYNC_STAGES+2 clk after ncs rises, txn_done one cycle, other regs 0x00.
- Full sweep: write 0x81AA, 0x8255, 0x8301, 0x8480 -> regs 0x01..0x04 = 0xAA, 0x55, 0x01, 0x80; reg 0x00 retains prior value.
- Rejects: addr 0x05 (0x8512), read frame 0x0433, 15-bit frame, 17-bit frame -> no register change, txn_error pulse each, txn_done never.
- Back-to-back: two frames with ncs high for minimum SYNC_STAGES+2 cycles between -> both commit in order; second write to same address overwrites first.
- Priority: ncs rising coincident with a final sclk rising edge (17th edge) -> edge ignored, count=16, write commits.
